// File: rtl/pattern_gen.sv
// pattern_gen
// -----------
// Multi-mode test-pattern generator placed between the video timing generator
// and the RGB output stage. Produces colour bars, a checkerboard, a horizontal
// grey ramp or a solid colour. The requested mode is only taken at frame
// start, and every pixel goes through a fixed two-register pipeline.
//
// Optional build macro: PGEN_BORDER_EN
//   Defined  : a one-pixel full-white frame is drawn on the active-area edges
//              in every mode (still blanked by video_on).
//   Undefined: no border logic is built; the pattern is output unmodified.
//
// Parameters
//   H_ACTIVE  active pixels per line (default 640)
//   V_ACTIVE  active lines per frame (default 480)
//   BARS      number of colour bars, 1..16 (default 8)
//   CW        colour channel width, 4..10 (default 8)
//   CHK_LOG2  checker square size is 2^CHK_LOG2 pixels (default 5)
//
// Ports
//   rfr_clk      in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   video_on     in   active-video qualifier from the timing generator
//   pixel_cnt    in   12-bit current pixel, 0-based
//   line_cnt     in   12-bit current line, 0-based
//   mode         in   2-bit requested pattern: 0 bars, 1 checker, 2 ramp, 3 solid
//   solid_rgb    in   3*CW solid colour {R,G,B}, captured together with mode
//   p_red        out  CW-bit red channel
//   p_green      out  CW-bit green channel
//   p_blue       out  CW-bit blue channel
//   active_mode  out  2-bit mode currently in effect
//
// Data flow: one pixel per clock, no stalls. Inputs sampled on one rising edge
// reach the outputs on the following rising edge (two register stages).

module pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BARS     = 8,
  parameter int CW       = 8,
  parameter int CHK_LOG2 = 5
) (
  input  logic            rfr_clk,
  input  logic            reset_n,
  input  logic            video_on,
  input  logic [11:0]     pixel_cnt,
  input  logic [11:0]     line_cnt,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] solid_rgb,
  output logic [CW-1:0]   p_red,
  output logic [CW-1:0]   p_green,
  output logic [CW-1:0]   p_blue,
  output logic [1:0]      active_mode
);

  // Elaboration-time sanity check on the parameter set.
  if (BARS < 1 || BARS > 16 || CW < 4 || CW > 10 || H_ACTIVE < BARS ||
      H_ACTIVE > 4096 || V_ACTIVE < 1 || V_ACTIVE > 4096 ||
      CHK_LOG2 < 0 || CHK_LOG2 > 11) begin : g_param_check
    $error("pattern_gen: illegal parameter combination");
  end

  localparam logic [1:0] MODE_BARS    = 2'd0;
  localparam logic [1:0] MODE_CHECKER = 2'd1;
  localparam logic [1:0] MODE_RAMP    = 2'd2;
  localparam logic [1:0] MODE_SOLID   = 2'd3;

  localparam int          BAR_W    = H_ACTIVE / BARS;
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);
  localparam logic [3:0]  BAR_MAX  = 4'(BARS - 1);

  // Ramp step: wide enough that the whole active line spans the colour range.
  localparam int          RAMP_S   = ($clog2(H_ACTIVE) > CW) ? ($clog2(H_ACTIVE) - CW) : 0;
  localparam logic [11:0] RAMP_MAX = 12'((1 << CW) - 1);

  localparam logic [CW-1:0] C_F = {CW{1'b1}};
  localparam logic [CW-1:0] C_H = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW-1:0] C_L = {3'b111, {(CW-3){1'b0}}};
  localparam logic [CW-1:0] C_0 = {CW{1'b0}};

  function automatic logic [3*CW-1:0] palette(input logic [3:0] idx);
    case (idx)
      4'd0:    palette = {C_F, C_F, C_F};  // white
      4'd1:    palette = {C_F, C_0, C_0};  // red
      4'd2:    palette = {C_F, C_H, C_0};  // orange
      4'd3:    palette = {C_F, C_F, C_0};  // yellow
      4'd4:    palette = {C_H, C_F, C_0};  // chartreuse
      4'd5:    palette = {C_0, C_F, C_0};  // green
      4'd6:    palette = {C_0, C_F, C_H};  // spring
      4'd7:    palette = {C_0, C_F, C_F};  // cyan
      4'd8:    palette = {C_0, C_H, C_F};  // azure
      4'd9:    palette = {C_0, C_0, C_F};  // blue
      4'd10:   palette = {C_H, C_0, C_F};  // violet
      4'd11:   palette = {C_F, C_0, C_F};  // magenta
      4'd12:   palette = {C_F, C_0, C_H};  // rose
      4'd13:   palette = {C_L, C_L, C_L};  // light grey
      4'd14:   palette = {C_H, C_H, C_H};  // mid grey
      default: palette = {C_0, C_0, C_0};  // black
    endcase
  endfunction

  // Frame/line start decode and bar tracking (stage 0, combinational)
  logic            frame_start;
  logic            line_start;
  logic [11:0]     cnt_q;
  logic [3:0]      bar_q;
  logic [11:0]     cur_cnt;
  logic [3:0]      cur_bar;
  logic [1:0]      eff_mode;
  logic [3*CW-1:0] solid_q;
  logic [3*CW-1:0] eff_solid;
  logic [11:0]     ramp_full;
  logic [CW-1:0]   ramp_sat;

  assign frame_start = (pixel_cnt == 12'd0) && (line_cnt == 12'd0);
  assign line_start  = (pixel_cnt == 12'd0);

  // The stored counters describe the pixel after the previous one; the line
  // start clear is applied to the current pixel so pixel 0 is always bar 0
  // and the clear wins over a simultaneous wrap.
  assign cur_cnt = line_start ? 12'd0 : cnt_q;
  assign cur_bar = line_start ? 4'd0  : bar_q;

  // The frame-start pixel itself already uses the newly requested mode/colour.
  assign eff_mode  = frame_start ? mode      : active_mode;
  assign eff_solid = frame_start ? solid_rgb : solid_q;

  assign ramp_full = pixel_cnt >> RAMP_S;
  assign ramp_sat  = (ramp_full > RAMP_MAX) ? C_F : ramp_full[CW-1:0];

  // Stage 1 registers
  logic [1:0]      s1_mode;
  logic [3:0]      s1_bar;
  logic            s1_chk;
  logic [CW-1:0]   s1_ramp;
  logic [3*CW-1:0] s1_solid;
  logic            s1_von;

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      active_mode <= MODE_BARS;
      solid_q     <= '0;
      cnt_q       <= 12'd0;
      bar_q       <= 4'd0;
      s1_mode     <= MODE_BARS;
      s1_bar      <= 4'd0;
      s1_chk      <= 1'b0;
      s1_ramp     <= '0;
      s1_solid    <= '0;
      s1_von      <= 1'b0;
    end else begin
      if (frame_start) begin
        active_mode <= mode;
        solid_q     <= solid_rgb;
      end
      if (cur_cnt == BAR_LAST) begin
        cnt_q <= 12'd0;
        bar_q <= (cur_bar == BAR_MAX) ? cur_bar : cur_bar + 4'd1;
      end else begin
        cnt_q <= cur_cnt + 12'd1;
        bar_q <= cur_bar;
      end
      s1_mode  <= eff_mode;
      s1_bar   <= cur_bar;
      s1_chk   <= pixel_cnt[CHK_LOG2] ^ line_cnt[CHK_LOG2];
      s1_ramp  <= ramp_sat;
      s1_solid <= eff_solid;
      s1_von   <= video_on;
    end
  end

`ifdef PGEN_BORDER_EN
  // Border flag travels alongside its pixel through stage 1.
  logic s1_border;

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_border <= 1'b0;
    end else begin
      s1_border <= (pixel_cnt == 12'd0) || (pixel_cnt == 12'(H_ACTIVE - 1)) ||
                   (line_cnt == 12'd0)  || (line_cnt == 12'(V_ACTIVE - 1));
    end
  end
`endif

  // Stage 2: colour lookup and blanking
  logic [3*CW-1:0] colour;

  always_comb begin
    colour = '0;
    case (s1_mode)
      MODE_BARS:    colour = palette(s1_bar);
      MODE_CHECKER: colour = s1_chk ? {C_0, C_0, C_0} : {C_F, C_F, C_F};
      MODE_RAMP:    colour = {s1_ramp, s1_ramp, s1_ramp};
      MODE_SOLID:   colour = s1_solid;
      default:      colour = '0;
    endcase
`ifdef PGEN_BORDER_EN
    if (s1_border) begin
      colour = {C_F, C_F, C_F};
    end
`endif
  end

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      p_red   <= '0;
      p_green <= '0;
      p_blue  <= '0;
    end else if (s1_von) begin
      p_red   <= colour[3*CW-1:2*CW];
      p_green <= colour[2*CW-1:CW];
      p_blue  <= colour[CW-1:0];
    end else begin
      p_red   <= '0;
      p_green <= '0;
      p_blue  <= '0;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Testbench for pattern_gen with default parameters (640x480, 8 bars, CW=8).
// The driver pushes the expected colour of every checked pixel into exp_q; a
// monitor pops and compares whenever a checked pixel reaches the outputs.

module tb_pattern_gen;

  logic        rfr_clk = 1'b0;
  logic        reset_n;
  logic        video_on;
  logic [11:0] pixel_cnt;
  logic [11:0] line_cnt;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic [7:0]  p_red;
  logic [7:0]  p_green;
  logic [7:0]  p_blue;
  logic [1:0]  active_mode;

  // Clock / reset
  always #5 rfr_clk = ~rfr_clk;

  pattern_gen dut (
    .rfr_clk     (rfr_clk),
    .reset_n     (reset_n),
    .video_on    (video_on),
    .pixel_cnt   (pixel_cnt),
    .line_cnt    (line_cnt),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .p_red       (p_red),
    .p_green     (p_green),
    .p_blue      (p_blue),
    .active_mode (active_mode)
  );

  // Hand-written palette for CW=8 (full=FF, half=80, light grey=E0).
  localparam logic [23:0] PAL [16] = '{
    24'hFFFFFF, 24'hFF0000, 24'hFF8000, 24'hFFFF00,
    24'h80FF00, 24'h00FF00, 24'h00FF80, 24'h00FFFF,
    24'h0080FF, 24'h0000FF, 24'h8000FF, 24'hFF00FF,
    24'hFF0080, 24'hE0E0E0, 24'h808080, 24'h000000
  };

  // Scoreboard state
  logic [23:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        chk_now  = 1'b0;
  logic [1:0]  chk_pipe;
  logic [1:0]  m_mode;
  logic [23:0] m_solid;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model for sequential sweeps starting at pixel 0.
  function automatic logic [23:0] model_rgb(input logic [1:0] md, input int px,
                                            input int ln, input logic [23:0] solid);
    int v;
    logic [7:0] v8;
    model_rgb = 24'h0;
    case (md)
      2'd0: model_rgb = PAL[(px < 560) ? px / 80 : 7];
      2'd1: model_rgb = ((((px >> 5) ^ (ln >> 5)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      2'd2: begin
        v = px >> 2;
        if (v > 255) v = 255;
        v8 = 8'(v);
        model_rgb = {v8, v8, v8};
      end
      default: model_rgb = solid;
    endcase
  endfunction

  // Tracks which driven pixels are due at the outputs two edges later.
  always @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) chk_pipe <= 2'b00;
    else          chk_pipe <= {chk_pipe[0], chk_now};
  end

  // Monitor
  always @(posedge rfr_clk) begin
    #1;
    if (chk_pipe[1]) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pixel_underflow actual=%h expected=none t=%0t",
                 {p_red, p_green, p_blue}, $time);
      end else begin
        check("pixel", {p_red, p_green, p_blue}, exp_q.pop_front());
      end
    end
  end

  // Driver: one pixel per call, applied on the falling edge.
  task automatic drive(input int px, input int ln, input logic von, input logic [1:0] md,
                       input logic [23:0] solid, input logic chk, input logic use_model,
                       input logic [23:0] hand);
    logic [23:0] e;
    @(negedge rfr_clk);
    pixel_cnt = 12'(px);
    line_cnt  = 12'(ln);
    video_on  = von;
    mode      = md;
    solid_rgb = solid;
    chk_now   = chk;
    if (px == 0 && ln == 0) begin
      m_mode  = md;
      m_solid = solid;
    end
    if (chk) begin
      e = use_model ? model_rgb(m_mode, px, ln, m_solid) : hand;
`ifdef PGEN_BORDER_EN
      if (px == 0 || px == 639 || ln == 0 || ln == 479) e = 24'hFFFFFF;
`endif
      if (!von) e = 24'h0;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_mode(input string name, input logic [1:0] exp);
    @(posedge rfr_clk);
    #2;
    check(name, {22'd0, active_mode}, {22'd0, exp});
  endtask

  initial begin
    reset_n   = 1'b0;
    video_on  = 1'b0;
    pixel_cnt = 12'd0;
    line_cnt  = 12'd0;
    mode      = 2'd0;
    solid_rgb = 24'h0;
    m_mode    = 2'd0;
    m_solid   = 24'h0;

    // Reset state
    #2;
    check("reset_rgb", {p_red, p_green, p_blue}, 24'h0);
    check("reset_mode", {22'd0, active_mode}, 24'h0);
    repeat (2) @(negedge rfr_clk);
    reset_n = 1'b1;

    // Bars: frame start in mode 0, then a full line
    drive(0, 0, 1'b1, 2'd0, 24'h0, 1'b1, 1'b1, 24'h0);
    for (int px = 0; px < 640; px++) drive(px, 1, 1'b1, 2'd0, 24'h0, 1'b1, 1'b1, 24'h0);

    // Mid-frame request for checker is ignored until the next frame start
    for (int px = 0; px < 10; px++) drive(px, 100, 1'b1, 2'd1, 24'h0, 1'b1, 1'b1, 24'h0);
    check_mode("midframe_mode", 2'd0);
    for (int px = 0; px < 10; px++) drive(px, 479, 1'b1, 2'd1, 24'h0, 1'b1, 1'b1, 24'h0);
    check_mode("end_of_frame_mode", 2'd0);
    drive(0, 0, 1'b1, 2'd1, 24'h0, 1'b1, 1'b0, 24'hFFFFFF);
    check_mode("checker_mode", 2'd1);
    for (int px = 1; px < 41; px++) drive(px, 0, 1'b1, 2'd1, 24'h0, 1'b1, 1'b1, 24'h0);
    drive(32, 0, 1'b1, 2'd1, 24'h0, 1'b1, 1'b0, 24'h000000);
    for (int px = 0; px < 41; px++) drive(px, 32, 1'b1, 2'd1, 24'h0, 1'b1, 1'b1, 24'h0);
    drive(32, 32, 1'b1, 2'd1, 24'h0, 1'b1, 1'b0, 24'hFFFFFF);

    // Ramp, hand values (S=2)
    drive(0, 0, 1'b1, 2'd2, 24'h0, 1'b1, 1'b0, 24'h000000);
    check_mode("ramp_mode", 2'd2);
    drive(3,    0, 1'b1, 2'd2, 24'h0, 1'b1, 1'b0, 24'h000000);
    drive(4,    0, 1'b1, 2'd2, 24'h0, 1'b1, 1'b0, 24'h010101);
    drive(639,  0, 1'b1, 2'd2, 24'h0, 1'b1, 1'b0, 24'h9F9F9F);
    drive(1019, 0, 1'b1, 2'd2, 24'h0, 1'b1, 1'b0, 24'hFEFEFE);
    drive(1023, 0, 1'b1, 2'd2, 24'h0, 1'b1, 1'b0, 24'hFFFFFF);
    drive(4095, 0, 1'b1, 2'd2, 24'h0, 1'b1, 1'b0, 24'hFFFFFF);

    // Solid and blanking; a later solid_rgb change is ignored
    drive(0, 0, 1'b1, 2'd3, 24'h123456, 1'b1, 1'b0, 24'h123456);
    check_mode("solid_mode", 2'd3);
    drive(1, 0, 1'b1, 2'd3, 24'h123456, 1'b1, 1'b0, 24'h123456);
    drive(2, 0, 1'b1, 2'd0, 24'hABCDEF, 1'b1, 1'b0, 24'h123456);
    drive(3, 0, 1'b0, 2'd0, 24'hABCDEF, 1'b1, 1'b0, 24'h000000);
    drive(4, 0, 1'b0, 2'd0, 24'hABCDEF, 1'b1, 1'b0, 24'h000000);
    drive(5, 0, 1'b1, 2'd0, 24'hABCDEF, 1'b1, 1'b0, 24'h123456);
    drive(6, 0, 1'b1, 2'd0, 24'hABCDEF, 1'b1, 1'b0, 24'h123456);

    // Reset mid-line in checker mode
    drive(0, 0, 1'b1, 2'd1, 24'h0, 1'b1, 1'b1, 24'h0);
    for (int px = 1; px < 300; px++) drive(px, 0, 1'b1, 2'd1, 24'h0, 1'b1, 1'b1, 24'h0);
    drive(300, 0, 1'b1, 2'd1, 24'h0, 1'b0, 1'b1, 24'h0);
    @(posedge rfr_clk);
    #3;
    reset_n = 1'b0;
    chk_now = 1'b0;
    exp_q.delete();
    m_mode  = 2'd0;
    m_solid = 24'h0;
    #1;
    check("async_reset_rgb", {p_red, p_green, p_blue}, 24'h0);
    check("async_reset_mode", {22'd0, active_mode}, 24'h0);
    @(negedge rfr_clk);
    reset_n = 1'b1;
    for (int px = 301; px < 640; px++) drive(px, 0, 1'b1, 2'd1, 24'h0, 1'b0, 1'b1, 24'h0);
    for (int px = 0; px < 640; px++) drive(px, 1, 1'b1, 2'd1, 24'h0, 1'b1, 1'b1, 24'h0);
    check_mode("post_reset_mode", 2'd0);

`ifdef PGEN_BORDER_EN
    // Border over a black solid field
    drive(0, 0, 1'b1, 2'd3, 24'h000000, 1'b1, 1'b0, 24'hFFFFFF);
    drive(5, 0, 1'b1, 2'd3, 24'h000000, 1'b1, 1'b0, 24'hFFFFFF);
    drive(0, 5, 1'b1, 2'd3, 24'h000000, 1'b1, 1'b0, 24'hFFFFFF);
    drive(5, 5, 1'b1, 2'd3, 24'h000000, 1'b1, 1'b0, 24'h000000);
    drive(639, 5, 1'b1, 2'd3, 24'h000000, 1'b1, 1'b0, 24'hFFFFFF);
    drive(5, 479, 1'b1, 2'd3, 24'h000000, 1'b1, 1'b0, 24'hFFFFFF);
    drive(0, 0, 1'b0, 2'd3, 24'h000000, 1'b1, 1'b0, 24'h000000);
`endif

    // Drain the pipeline, then every expectation must have been consumed
    repeat (4) drive(5, 5, 1'b0, 2'd0, 24'h0, 1'b0, 1'b0, 24'h0);
    check("queue_empty", 24'(exp_q.size()), 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
